// File: rtl/hls_stream_bridge.sv
// Host-file to HLS ap_fifo bridge: one inbound and one outbound FIFO per channel,
// with a prefetch stage on the IP read side, EOF tracking and a registered status port.
module hls_stream_bridge #(
    parameter int NCH = 2,
    parameter int DW  = 128,
    parameter int AW  = 9
) (
    input  logic              bus_clk,
    input  logic              rst,
    input  logic [NCH-1:0]    w_wren,
    output logic [NCH-1:0]    w_full,
    input  logic [NCH-1:0]    w_open,
    input  logic [NCH*DW-1:0] w_data,
    input  logic [NCH-1:0]    r_rden,
    input  logic [NCH-1:0]    r_open,
    output logic [NCH-1:0]    r_empty,
    output logic [NCH-1:0]    r_eof,
    output logic [NCH*DW-1:0] r_data,
    output logic [NCH*DW-1:0] in_dout,
    output logic [NCH-1:0]    in_empty_n,
    input  logic [NCH-1:0]    in_read,
    input  logic [NCH*DW-1:0] out_din,
    input  logic [NCH-1:0]    out_write,
    output logic [NCH-1:0]    out_full,
    input  logic [NCH-1:0]    ip_done,
    output logic [NCH-1:0]    ip_rst_n,
    input  logic [2:0]        stat_ch,
    input  logic [1:0]        stat_kind,
    output logic [31:0]       stat_data
);
    localparam int DEPTH = 2**AW;

    logic [31:0] stat_words_in  [NCH];
    logic [31:0] stat_words_out [NCH];
    logic [31:0] stat_counts    [NCH];
    logic [31:0] stat_flags     [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic          clr;
        logic          in_push, in_pop, out_push, out_pop;
        logic [DW-1:0] in_mem  [DEPTH];
        logic [DW-1:0] out_mem [DEPTH];
        logic [AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
        logic [AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
        logic [AW:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
        logic [DW-1:0] in_dout_q, in_dout_d, r_data_q, r_data_d;
        logic          in_empty_n_q, in_empty_n_d;
        logic          done_q, done_d;
        logic          ip_rst_n_q, ip_rst_n_d;
        logic [31:0]   in_words_q, in_words_d, out_words_q, out_words_d;

        assign clr = rst | ~(w_open[c] | r_open[c]);

        // Count never exceeds DEPTH, so its MSB alone flags full.
        assign w_full[c]   = in_cnt_q[AW];
        assign out_full[c] = out_cnt_q[AW];
        assign r_empty[c]  = (out_cnt_q == '0);
        assign r_eof[c]    = done_q & r_empty[c];

        assign in_push  = w_wren[c] & ~w_full[c] & ~clr;
        assign in_pop   = (in_cnt_q != '0) & (in_read[c] | ~in_empty_n_q) & ~clr;
        assign out_push = out_write[c] & ~out_full[c] & ~clr;
        assign out_pop  = r_rden[c] & ~r_empty[c] & ~clr;

        assign in_dout[c*DW +: DW] = in_dout_q;
        assign r_data[c*DW +: DW]  = r_data_q;
        assign in_empty_n[c]       = in_empty_n_q;
        assign ip_rst_n[c]         = ip_rst_n_q;

        assign stat_words_in[c]  = in_words_q;
        assign stat_words_out[c] = out_words_q;
        assign stat_counts[c]    = {16'(in_cnt_q), 16'(out_cnt_q)};
        assign stat_flags[c]     = {27'd0, done_q, r_eof[c], w_full[c], out_full[c], ip_rst_n_q};

        always_ff @(posedge bus_clk) begin
            if (in_push)  in_mem[in_wp_q]   <= w_data[c*DW +: DW];
            if (out_push) out_mem[out_wp_q] <= out_din[c*DW +: DW];
        end

        always_comb begin
            in_wp_d      = in_wp_q;
            in_rp_d      = in_rp_q;
            out_wp_d     = out_wp_q;
            out_rp_d     = out_rp_q;
            in_cnt_d     = in_cnt_q;
            out_cnt_d    = out_cnt_q;
            in_dout_d    = in_dout_q;
            r_data_d     = r_data_q;
            in_empty_n_d = in_empty_n_q;
            done_d       = done_q;
            in_words_d   = in_words_q;
            out_words_d  = out_words_q;
            ip_rst_n_d   = ~clr;
            if (clr) begin
                in_wp_d      = '0;
                in_rp_d      = '0;
                out_wp_d     = '0;
                out_rp_d     = '0;
                in_cnt_d     = '0;
                out_cnt_d    = '0;
                in_dout_d    = '0;
                r_data_d     = '0;
                in_empty_n_d = 1'b0;
                done_d       = 1'b0;
                in_words_d   = '0;
                out_words_d  = '0;
            end else begin
                if (in_push) begin
                    in_wp_d    = in_wp_q + AW'(1);
                    in_words_d = in_words_q + 32'd1;
                end
                if (in_pop) begin
                    in_rp_d      = in_rp_q + AW'(1);
                    in_dout_d    = in_mem[in_rp_q];
                    in_empty_n_d = 1'b1;
                end else if (in_read[c]) begin
                    in_empty_n_d = 1'b0;
                end
                in_cnt_d = in_cnt_q + (AW+1)'(in_push) - (AW+1)'(in_pop);

                if (out_push) begin
                    out_wp_d    = out_wp_q + AW'(1);
                    out_words_d = out_words_q + 32'd1;
                end
                if (out_pop) begin
                    out_rp_d = out_rp_q + AW'(1);
                    r_data_d = out_mem[out_rp_q];
                end
                out_cnt_d = out_cnt_q + (AW+1)'(out_push) - (AW+1)'(out_pop);

                if (ip_done[c]) done_d = 1'b1;
            end
        end

        always_ff @(posedge bus_clk) begin
            if (rst) begin
                in_wp_q      <= '0;
                in_rp_q      <= '0;
                out_wp_q     <= '0;
                out_rp_q     <= '0;
                in_cnt_q     <= '0;
                out_cnt_q    <= '0;
                in_dout_q    <= '0;
                r_data_q     <= '0;
                in_empty_n_q <= 1'b0;
                done_q       <= 1'b0;
                ip_rst_n_q   <= 1'b0;
                in_words_q   <= '0;
                out_words_q  <= '0;
            end else begin
                in_wp_q      <= in_wp_d;
                in_rp_q      <= in_rp_d;
                out_wp_q     <= out_wp_d;
                out_rp_q     <= out_rp_d;
                in_cnt_q     <= in_cnt_d;
                out_cnt_q    <= out_cnt_d;
                in_dout_q    <= in_dout_d;
                r_data_q     <= r_data_d;
                in_empty_n_q <= in_empty_n_d;
                done_q       <= done_d;
                ip_rst_n_q   <= ip_rst_n_d;
                in_words_q   <= in_words_d;
                out_words_q  <= out_words_d;
            end
        end
    end

    logic [31:0] stat_data_q, stat_data_d;

    // Channels at or above NCH never match, so they read back as zero.
    always_comb begin
        stat_data_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (stat_ch == 3'(c)) begin
                case (stat_kind)
                    2'd0:    stat_data_d = stat_words_in[c];
                    2'd1:    stat_data_d = stat_words_out[c];
                    2'd2:    stat_data_d = stat_counts[c];
                    default: stat_data_d = stat_flags[c];
                endcase
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (rst) stat_data_q <= '0;
        else     stat_data_q <= stat_data_d;
    end

    assign stat_data = stat_data_q;

endmodule

// File: tb/tb_hls_stream_bridge.sv
// Directed bench for hls_stream_bridge (NCH=2, DW=16, AW=2): a vector table for the
// channel-0 streaming/EOF sequence plus hand-written full, close and reset sequences.
module tb_hls_stream_bridge;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 2;

    logic              bus_clk;
    logic              rst;
    logic [NCH-1:0]    w_wren, w_full, w_open;
    logic [NCH*DW-1:0] w_data;
    logic [NCH-1:0]    r_rden, r_open, r_empty, r_eof;
    logic [NCH*DW-1:0] r_data, in_dout, out_din;
    logic [NCH-1:0]    in_empty_n, in_read, out_write, out_full, ip_done, ip_rst_n;
    logic [2:0]        stat_ch;
    logic [1:0]        stat_kind;
    logic [31:0]       stat_data;

    hls_stream_bridge #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .bus_clk(bus_clk), .rst(rst),
        .w_wren(w_wren), .w_full(w_full), .w_open(w_open), .w_data(w_data),
        .r_rden(r_rden), .r_open(r_open), .r_empty(r_empty), .r_eof(r_eof), .r_data(r_data),
        .in_dout(in_dout), .in_empty_n(in_empty_n), .in_read(in_read),
        .out_din(out_din), .out_write(out_write), .out_full(out_full),
        .ip_done(ip_done), .ip_rst_n(ip_rst_n),
        .stat_ch(stat_ch), .stat_kind(stat_kind), .stat_data(stat_data)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    typedef struct {
        logic        wren;
        logic [15:0] wd;
        logic        rd_in;
        logic        owr;
        logic [15:0] od;
        logic        rden;
        logic        done;
        logic [2:0]  sch;
        logic [1:0]  sk;
        logic        e_empty_n;
        logic [15:0] e_dout;
        logic        e_r_empty;
        logic [15:0] e_r_data;
        logic        e_eof;
        logic        e_w_full;
        logic        e_out_full;
        logic [31:0] e_stat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // inputs: wren wd rd_in owr od rden done sch sk | expected after the edge
        vecs[0]  = '{1'b1, 16'h1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 16'h2, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b1, 16'h1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h1};
        vecs[2]  = '{1'b1, 16'h3, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b1, 16'h2, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h2};
        vecs[3]  = '{1'b1, 16'h4, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b1, 16'h3, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h3};
        vecs[4]  = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b1, 16'h4, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h4};
        vecs[5]  = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 2'd0,  1'b0, 16'h4, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 32'h4};
        vecs[6]  = '{1'b0, 16'h0, 1'b0, 1'b1, 16'hA, 1'b0, 1'b0, 3'd0, 2'd1,  1'b0, 16'h4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 16'h0, 1'b0, 1'b1, 16'hB, 1'b0, 1'b0, 3'd0, 2'd1,  1'b0, 16'h4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h1};
        vecs[8]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0, 2'd3,  1'b0, 16'h4, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h1};
        vecs[9]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 2'd3,  1'b0, 16'h4, 1'b0, 16'hA, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[10] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 2'd2,  1'b0, 16'h4, 1'b1, 16'hB, 1'b1, 1'b0, 1'b0, 32'h1};
        vecs[11] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'hC, 1'b0, 1'b0, 3'd0, 2'd3,  1'b0, 16'h4, 1'b0, 16'hB, 1'b0, 1'b0, 1'b0, 32'h19};
        vecs[12] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'hD, 1'b1, 1'b0, 3'd0, 2'd1,  1'b0, 16'h4, 1'b0, 16'hC, 1'b0, 1'b0, 1'b0, 32'h3};
        vecs[13] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 2'd1,  1'b0, 16'h4, 1'b1, 16'hD, 1'b1, 1'b0, 1'b0, 32'h4};
        vecs[14] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 3'd2, 2'd0,  1'b0, 16'h4, 1'b1, 16'hD, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd1, 2'd3,  1'b0, 16'h4, 1'b1, 16'hD, 1'b1, 1'b0, 1'b0, 32'h0};

        rst = 1'b1;
        w_wren = '0; w_open = '0; w_data = '0;
        r_rden = '0; r_open = '0; in_read = '0;
        out_din = '0; out_write = '0; ip_done = '0;
        stat_ch = '0; stat_kind = '0;

        // Reset state
        step(); step();
        chk("rst w_full", 32'(w_full), 32'h0);
        chk("rst r_empty", 32'(r_empty), 32'h3);
        chk("rst r_eof", 32'(r_eof), 32'h0);
        chk("rst in_empty_n", 32'(in_empty_n), 32'h0);
        chk("rst in_dout", in_dout, 32'h0);
        chk("rst r_data", r_data, 32'h0);
        chk("rst out_full", 32'(out_full), 32'h0);
        chk("rst ip_rst_n", 32'(ip_rst_n), 32'h0);
        chk("rst stat", stat_data, 32'h0);

        rst = 1'b0;
        w_open[0] = 1'b1;
        step();
        chk("open ip_rst_n", 32'(ip_rst_n), 32'h1);
        step();

        // Table: streaming latency, back-to-back reads, outbound EOF, status decode
        for (int i = 0; i < 16; i++) begin
            w_wren[0] = vecs[i].wren;    w_data[15:0]  = vecs[i].wd;
            in_read[0] = vecs[i].rd_in;
            out_write[0] = vecs[i].owr;  out_din[15:0] = vecs[i].od;
            r_rden[0] = vecs[i].rden;    ip_done[0]    = vecs[i].done;
            stat_ch = vecs[i].sch;       stat_kind     = vecs[i].sk;
            step();
            chk($sformatf("v%0d in_empty_n", i), 32'(in_empty_n[0]), 32'(vecs[i].e_empty_n));
            chk($sformatf("v%0d in_dout", i), 32'(in_dout[15:0]), 32'(vecs[i].e_dout));
            chk($sformatf("v%0d r_empty", i), 32'(r_empty[0]), 32'(vecs[i].e_r_empty));
            chk($sformatf("v%0d r_data", i), 32'(r_data[15:0]), 32'(vecs[i].e_r_data));
            chk($sformatf("v%0d r_eof", i), 32'(r_eof[0]), 32'(vecs[i].e_eof));
            chk($sformatf("v%0d w_full", i), 32'(w_full[0]), 32'(vecs[i].e_w_full));
            chk($sformatf("v%0d out_full", i), 32'(out_full[0]), 32'(vecs[i].e_out_full));
            chk($sformatf("v%0d stat", i), stat_data, vecs[i].e_stat);
        end
        w_wren = '0; in_read = '0; out_write = '0; r_rden = '0; ip_done = '0;
        stat_ch = 3'd0; stat_kind = 2'd0;

        // Close ch0 clears it; reopen releases the IP one cycle later
        w_open[0] = 1'b0;
        step();
        chk("close0 ip_rst_n", 32'(ip_rst_n[0]), 32'h0);
        chk("close0 r_eof", 32'(r_eof[0]), 32'h0);
        chk("close0 r_data", 32'(r_data[15:0]), 32'h0);
        chk("close0 in_dout", 32'(in_dout[15:0]), 32'h0);
        w_open[0] = 1'b1;
        step();
        chk("reopen0 ip_rst_n", 32'(ip_rst_n[0]), 32'h1);
        step();
        chk("reopen0 in_words", stat_data, 32'h0);

        // Inbound full: 4 in FIFO + 1 prefetched, 6th write dropped
        for (int i = 0; i < 6; i++) begin
            w_wren[0] = 1'b1;
            w_data[15:0] = 16'(16'h11 + i);
            step();
            if (i == 3) chk("fill w_full@4", 32'(w_full[0]), 32'h0);
            if (i >= 4) chk($sformatf("fill w_full@%0d", i + 1), 32'(w_full[0]), 32'h1);
        end
        w_wren[0] = 1'b0;
        step();
        chk("fill in_words", stat_data, 32'h5);
        chk("fill in_empty_n", 32'(in_empty_n[0]), 32'h1);
        chk("fill in_dout", 32'(in_dout[15:0]), 32'h11);
        in_read[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("drain in_dout%0d", k), 32'(in_dout[15:0]), 32'(16'h12 + k));
            chk($sformatf("drain empty_n%0d", k), 32'(in_empty_n[0]), 32'h1);
            if (k == 0) chk("drain w_full", 32'(w_full[0]), 32'h0);
        end
        step();
        chk("drain done empty_n", 32'(in_empty_n[0]), 32'h0);
        in_read[0] = 1'b0;

        // ch1: simultaneous push/pop keeps count, then close discards everything
        w_open[1] = 1'b1;
        step();
        chk("open1 ip_rst_n", 32'(ip_rst_n), 32'h3);
        out_write[1] = 1'b1; out_din[31:16] = 16'h31; step();
        out_din[31:16] = 16'h32; step();
        out_din[31:16] = 16'h33; r_rden[1] = 1'b1; step();
        chk("ch1 pushpop r_data", 32'(r_data[31:16]), 32'h31);
        out_write[1] = 1'b0; r_rden[1] = 1'b0;
        stat_ch = 3'd1; stat_kind = 2'd2;
        step();
        chk("ch1 counts out", stat_data, 32'h0000_0002);
        w_wren[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data[31:16] = 16'(16'h21 + i);
            step();
        end
        w_wren[1] = 1'b0;
        step();
        chk("ch1 counts both", stat_data, 32'h0002_0002);
        ip_done[1] = 1'b1; step(); ip_done[1] = 1'b0;
        chk("ch1 eof pending", 32'(r_eof[1]), 32'h0);
        stat_ch = 3'd0; stat_kind = 2'd3;
        step();
        chk("ch0 flags before", stat_data, 32'h1);
        w_open[1] = 1'b0;
        stat_ch = 3'd1; stat_kind = 2'd2;
        step();
        chk("close1 ip_rst_n", 32'(ip_rst_n), 32'h1);
        chk("close1 r_eof", 32'(r_eof[1]), 32'h0);
        chk("close1 r_empty", 32'(r_empty[1]), 32'h1);
        chk("close1 in_empty_n", 32'(in_empty_n[1]), 32'h0);
        step();
        chk("close1 counts", stat_data, 32'h0);
        stat_ch = 3'd0; stat_kind = 2'd0;
        step();
        chk("ch0 in_words after", stat_data, 32'h5);
        stat_kind = 2'd3;
        step();
        chk("ch0 flags after", stat_data, 32'h1);

        // ch1 outbound full and ordered drain
        r_open[1] = 1'b1;
        step();
        out_write[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_din[31:16] = 16'(16'h41 + i);
            step();
            if (i == 2) chk("ofill out_full@3", 32'(out_full[1]), 32'h0);
            if (i >= 3) chk($sformatf("ofill out_full@%0d", i + 1), 32'(out_full[1]), 32'h1);
        end
        out_write[1] = 1'b0;
        stat_ch = 3'd1; stat_kind = 2'd1;
        step();
        chk("ofill out_words", stat_data, 32'h4);
        r_rden[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("odrain r_data%0d", k), 32'(r_data[31:16]), 32'(16'h41 + k));
            if (k == 0) chk("odrain out_full", 32'(out_full[1]), 32'h0);
        end
        chk("odrain r_empty", 32'(r_empty[1]), 32'h1);
        step();
        chk("odrain empty rden", 32'(r_data[31:16]), 32'h44);
        r_rden[1] = 1'b0;

        // Reset mid-stream with 3 words in each ch0 FIFO
        w_wren[0] = 1'b1; out_write[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data[15:0]  = 16'(16'h51 + i);
            out_din[15:0] = 16'(16'h61 + i);
            step();
        end
        w_wren[0] = 1'b0; out_write[0] = 1'b0;
        r_rden[0] = 1'b1; step(); r_rden[0] = 1'b0;
        chk("pre-rst in_empty_n", 32'(in_empty_n[0]), 32'h1);
        chk("pre-rst r_data", 32'(r_data[15:0]), 32'h61);
        stat_ch = 3'd0; stat_kind = 2'd2;
        step();
        chk("pre-rst counts", stat_data, 32'h0003_0003);
        rst = 1'b1;
        stat_kind = 2'd0;
        step();
        chk("mrst w_full", 32'(w_full), 32'h0);
        chk("mrst r_empty", 32'(r_empty), 32'h3);
        chk("mrst r_eof", 32'(r_eof), 32'h0);
        chk("mrst in_empty_n", 32'(in_empty_n), 32'h0);
        chk("mrst in_dout", in_dout, 32'h0);
        chk("mrst r_data", r_data, 32'h0);
        chk("mrst out_full", 32'(out_full), 32'h0);
        chk("mrst ip_rst_n", 32'(ip_rst_n), 32'h0);
        chk("mrst stat", stat_data, 32'h0);
        rst = 1'b0;
        step();
        chk("post-rst in_words", stat_data, 32'h0);
        chk("post-rst ip_rst_n", 32'(ip_rst_n), 32'h3);
        stat_kind = 2'd1;
        step();
        chk("post-rst out_words", stat_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
